// File: rtl/blinds_motor_drive.sv
// Stepper drive for the blinds: filters the requested level, then steps the motor
// to the matching absolute position with a dead-time brake after every move.
module blinds_motor_drive #(
    parameter int STEPS_PER_LEVEL = 8,
    parameter int STEP_DIV        = 2,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEAD_CYCLES     = 2,
    parameter int POS_W           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       target,
    input  logic             enable,
    output logic             motor_up,
    output logic             motor_down,
    output logic             step,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             at_level
);
    // state     | meaning
    // IDLE      | motor off, waiting for a target different from position
    // SETTLE    | new target must hold SETTLE_CYCLES before motion
    // MOVE_UP   | driving toward position 0, one step per STEP_DIV cycles
    // MOVE_DOWN | driving toward the maximum position
    // BRAKE     | both outputs low for DEAD_CYCLES before returning to IDLE
    typedef enum logic [2:0] {IDLE, SETTLE, MOVE_UP, MOVE_DOWN, BRAKE} state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > DEAD_CYCLES) ? SETTLE_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(STEP_DIV + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] SPL_P       = POS_W'(STEPS_PER_LEVEL);
    localparam logic [POS_W-1:0] POS_MAX     = POS_W'(3 * STEPS_PER_LEVEL);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [POS_W-1:0] pos_q, pos_n, pos_step;
    logic [1:0]       lat_q, lat_n;
    logic [POS_W-1:0] tpos, lat_pos;
    logic             ready_q;

    assign tpos    = POS_W'(target) * SPL_P;
    assign lat_pos = POS_W'(lat_q) * SPL_P;

    // Saturating step keeps position inside 0..POS_MAX even if the target logic misbehaves.
    always_comb begin
        pos_step = pos_q;
        if (state_q == MOVE_DOWN) begin
            if (pos_q != POS_MAX) pos_step = pos_q + POS_W'(1);
        end else if (pos_q != '0) begin
            pos_step = pos_q - POS_W'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        div_n   = div_q;
        pos_n   = pos_q;
        lat_n   = lat_q;
        case (state_q)
            IDLE: begin
                div_n = '0;
                if (enable && (tpos != pos_q)) begin
                    lat_n   = target;
                    cnt_n   = SETTLE_LOAD;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (!enable || (tpos == pos_q)) begin
                    state_n = IDLE;
                end else if (target != lat_q) begin
                    lat_n = target;
                    cnt_n = SETTLE_LOAD;
                end else if (cnt_q == '0) begin
                    div_n   = '0;
                    state_n = (lat_pos > pos_q) ? MOVE_DOWN : MOVE_UP;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                // A step already in progress completes even if enable falls in the same cycle.
                if (div_q == DIV_LAST) begin
                    div_n = '0;
                    pos_n = pos_step;
                    if ((pos_step == lat_pos) || !enable) begin
                        cnt_n   = DEAD_LOAD;
                        state_n = BRAKE;
                    end
                end else if (!enable) begin
                    cnt_n   = DEAD_LOAD;
                    state_n = BRAKE;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            BRAKE: begin
                if (cnt_q == '0) state_n = IDLE;
                else             cnt_n   = cnt_q - CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            pos_q      <= '0;
            lat_q      <= '0;
            ready_q    <= 1'b0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            step       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            div_q      <= div_n;
            pos_q      <= pos_n;
            lat_q      <= lat_n;
            ready_q    <= 1'b1;
            motor_up   <= (state_n == MOVE_UP);
            motor_down <= (state_n == MOVE_DOWN);
            step       <= ((state_n == MOVE_UP) || (state_n == MOVE_DOWN)) && (div_n == DIV_LAST);
        end
    end

    assign position = pos_q;
    assign busy     = (state_q != IDLE);
    assign at_level = ready_q && (state_q == IDLE) && (pos_q == tpos);
endmodule
